// File: rtl/calc_core_seq.sv
// Sequential calculator core: operand registers, ALU, shift-add multiplier, restoring divider.
// Optional `CALC_FLAGS_EN adds a registered {divzero, cy_bw, zero} flags output.
module calc_core_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef CALC_FLAGS_EN
  output logic [2:0]       flags,
`endif
  output logic [WIDTH-1:0] out_h,
  output logic [WIDTH-1:0] out_l
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAlu  = 3'd1;
  localparam logic [2:0] StMul  = 3'd2;
  localparam logic [2:0] StDiv  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out_h;
  logic [WIDTH-1:0] r_out_l;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_alu_h;
  logic [WIDTH-1:0] w_alu_l;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic             w_iter_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_res_h;
  logic [WIDTH-1:0] w_res_l;

  assign busy  = (r_state == StAlu) || (r_state == StMul) || (r_state == StDiv);
  assign done  = (r_state == StDone);
  assign out_h = r_out_h;
  assign out_l = r_out_l;

  always_comb begin
    w_add   = {1'b0, r_a} + {1'b0, r_b};
    w_sub   = {1'b0, r_a} - {1'b0, r_b};
    w_alu_h = '0;
    w_alu_l = '0;
    case (r_op)
      3'b000: begin
        w_alu_l = w_add[WIDTH-1:0];
        w_alu_h = WIDTH'(w_add[WIDTH]);
      end
      3'b001: begin
        w_alu_l = w_sub[WIDTH-1:0];
        w_alu_h = WIDTH'(w_sub[WIDTH]);
      end
      3'b010:  w_alu_l = r_a & r_b;
      3'b011:  w_alu_l = r_a ^ r_b;
      3'b110:  w_alu_l = r_a;
      3'b111:  w_alu_l = r_b;
      // Divide-by-zero is the only divide that reaches the ALU path.
      default: w_alu_l = '0;
    endcase
  end

  // Multiplier: add A into the upper half when the current multiplier LSB is set.
  assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  // Divider: shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_trial = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_b});
  assign w_diff  = w_trial[WIDTH-1:0] - r_b;

  assign w_iter_last = (r_cnt == CW'(WIDTH));
  assign w_finish    = (r_state == StAlu) ||
                       (((r_state == StMul) || (r_state == StDiv)) && w_iter_last);
  assign w_res_h     = (r_state == StAlu) ? w_alu_h : r_hi;
  assign w_res_l     = (r_state == StAlu) ? w_alu_l : r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_out_h <= '0;
      r_out_l <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= (op == 3'b101) ? b : a;
            if (op == 3'b101) begin
              r_state <= StMul;
            end else if ((op == 3'b100) && (b != '0)) begin
              r_state <= StDiv;
            end else begin
              r_state <= StAlu;
            end
          end
        end
        StAlu: r_state <= StDone;
        StMul: begin
          if (w_iter_last) begin
            r_state <= StDone;
          end else begin
            {r_hi, r_lo} <= {w_msum, r_lo[WIDTH-1:1]};
            r_cnt        <= r_cnt + CW'(1);
          end
        end
        StDiv: begin
          if (w_iter_last) begin
            r_state <= StDone;
          end else begin
            r_hi  <= w_ge ? w_diff : w_trial[WIDTH-1:0];
            r_lo  <= {r_lo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      if (w_finish) begin
        r_out_h <= w_res_h;
        r_out_l <= w_res_l;
      end
    end
  end

`ifdef CALC_FLAGS_EN
  logic [2:0] r_flags;
  logic       w_cy_bw;

  assign w_cy_bw = (r_state == StAlu) &&
                   (((r_op == 3'b000) && w_add[WIDTH]) || ((r_op == 3'b001) && w_sub[WIDTH]));
  assign flags   = r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 3'b000;
    end else if (w_finish) begin
      r_flags <= {(r_op == 3'b100) && (r_b == '0), w_cy_bw, {w_res_h, w_res_l} == '0};
    end
  end
`endif

endmodule

// File: tb/tb_calc_core_seq.sv
// Bench for calc_core_seq at WIDTH=4: directed cases, back-to-back start, mid-op reset,
// exhaustive sweep and random ops against an arithmetic reference model.
module tb_calc_core_seq;

  localparam int unsigned W = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op    = '0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] out_h;
  logic [W-1:0] out_l;
`ifdef CALC_FLAGS_EN
  logic [2:0]   flags;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_core_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
`ifdef CALC_FLAGS_EN
    .flags (flags),
`endif
    .out_h (out_h),
    .out_l (out_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    int ia;
    int ib;
    ia = int'(x);
    ib = int'(y);
    case (o)
      3'd0:    return (2*W)'(ia + ib);
      3'd1:    return {W'((ia < ib) ? 1 : 0), W'(ia - ib)};
      3'd2:    return (2*W)'(x & y);
      3'd3:    return (2*W)'(x ^ y);
      3'd4:    return (ib == 0) ? '0 : {W'(ia % ib), W'(ia / ib)};
      3'd5:    return (2*W)'(ia * ib);
      3'd6:    return (2*W)'(ia);
      default: return (2*W)'(ib);
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] exp;
    int             lat;
    int             cyc;
    int             n;
    logic           busy_ok;
    exp = model(o, x, y);
    lat = ((o == 3'd5) || ((o == 3'd4) && (y != '0))) ? W + 2 : 2;
    n = 0;
    while (!((busy === 1'b0) && (done === 1'b0)) && (n < 20)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", 32'(n < 20), 32'd1);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the core must work from its latched copies.
    start   = 1'b0;
    op      = 3'($urandom);
    a       = W'($urandom);
    b       = W'($urandom);
    cyc     = 1;
    busy_ok = 1'b1;
    while ((done !== 1'b1) && (cyc < 40)) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("latency op=%0d a=%0h b=%0h", o, x, y), 32'(cyc), 32'(lat));
    chk($sformatf("busy_while_running op=%0d", o), 32'(busy_ok), 32'd1);
    chk($sformatf("busy_in_done op=%0d", o), 32'(busy), 32'd0);
    chk($sformatf("out_h op=%0d a=%0h b=%0h", o, x, y), 32'(out_h), 32'(exp[2*W-1:W]));
    chk($sformatf("out_l op=%0d a=%0h b=%0h", o, x, y), 32'(out_l), 32'(exp[W-1:0]));
`ifdef CALC_FLAGS_EN
    begin
      logic [2:0] ef;
      ef[2] = (o == 3'd4) && (y == '0);
      ef[1] = (o == 3'd0) ? ((int'(x) + int'(y)) >= (1 << W)) :
              (o == 3'd1) ? (x < y) : 1'b0;
      ef[0] = (exp == '0);
      chk($sformatf("flags op=%0d a=%0h b=%0h", o, x, y), 32'(flags), 32'(ef));
    end
`endif
    @(posedge clk); #1;
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("hold_result", 32'({out_h, out_l}), 32'(exp));
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", 32'({out_h, out_l}), 32'd0);
`ifdef CALC_FLAGS_EN
    chk("reset_flags", 32'(flags), 32'd0);
`endif
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Directed boundary cases.
    run_op(3'd0, 4'hF, 4'h1);
    chk("add_carry", 32'({out_h, out_l}), 32'h10);
    run_op(3'd1, 4'h3, 4'h5);
    chk("sub_borrow", 32'({out_h, out_l}), 32'h1E);
    run_op(3'd5, 4'hF, 4'hF);
    chk("mul_max", 32'({out_h, out_l}), 32'hE1);
    run_op(3'd4, 4'd13, 4'd4);
    chk("div_13_4", 32'({out_h, out_l}), 32'h13);
    run_op(3'd4, 4'd7, 4'd0);
    chk("div_by_zero", 32'({out_h, out_l}), 32'h00);
    run_op(3'd4, 4'd3, 4'd9);
    chk("div_a_lt_b", 32'({out_h, out_l}), 32'h30);

    // start held high across two back-to-back ALU ops.
    op    = 3'd3;
    a     = 4'hA;
    b     = 4'h6;
    start = 1'b1;
    @(posedge clk); #1;
    op = 3'd7;
    b  = 4'h9;
    chk("b2b_busy_first", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("b2b_done_first", 32'(done), 32'd1);
    chk("b2b_out_first", 32'({out_h, out_l}), 32'h0C);
    @(posedge clk); #1;
    chk("b2b_idle_gap", 32'({busy, done}), 32'd0);
    chk("b2b_hold_first", 32'({out_h, out_l}), 32'h0C);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy_second", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("b2b_done_second", 32'(done), 32'd1);
    chk("b2b_out_second", 32'({out_h, out_l}), 32'h09);
    @(posedge clk); #1;

    // Reset in the middle of a multiply aborts without a done pulse.
    op    = 3'd5;
    a     = 4'd9;
    b     = 4'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_mul_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_out", 32'({out_h, out_l}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'({busy, done}), 32'd0);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'({busy, done, out_h, out_l}), 32'd0);

    // Exhaustive sweep of every op and operand pair.
    for (int o = 0; o < 8; o++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          run_op(3'(o), W'(x), W'(y));
        end
      end
    end

    // Random ops.
    for (int i = 0; i < 200; i++) begin
      run_op(3'($urandom), W'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
